cp0_exception_unit: RTL and testbench

- Next-generation precise-exception block for the 5-stage MIPS pipeline, MEM stage.
- Merges exception prioritisation with the CP0 register state it depends on: BadVAddr, Count, Compare, Status, Cause and EPC.
- Adds a parametrised external-interrupt synchroniser, the Count/Compare timer interrupt, and delay-slot (BD) EPC correction.
- Records the committed exception state in the same cycle it redirects the PC.

---
 rtl/cp0_exception_unit_pkg.sv | 32 +++
 rtl/cp0_exception_unit_if.sv | 46 ++++
 rtl/cp0_exception_unit_int_sync.sv | 24 ++
 rtl/cp0_exception_unit.sv | 176 +++++++++++++++++
 tb/tb_cp0_exception_unit.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_exception_unit_pkg.sv
// Shared CP0 constants: register numbers, ExcCode values, field positions and reset values.
package cp0_exception_unit_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0a,
        EXC_OV   = 5'h0c,
        EXC_ERET = 5'h1f
    } exc_code_e;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LSB = 8;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 8;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_BD      = 31;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

endpackage

// File: rtl/cp0_exception_unit_if.sv
// MEM-stage exception bus between the pipeline (master) and the CP0 exception unit (slave).
interface cp0_exception_unit_if;

    logic        stall_m;
    logic        valid_m;
    logic [31:0] pc_m;
    logic        is_in_delayslot_m;
    logic [31:0] alu_out_m;
    logic        ri_m;
    logic        break_m;
    logic        syscall_m;
    logic        overflow_m;
    logic        adel_data_m;
    logic        ades_data_m;
    logic        pc_error_m;
    logic        eret_m;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        flush_exception;
    logic [31:0] pc_exception;
    logic [4:0]  exc_code;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        timer_int;

    modport master (
        output stall_m, valid_m, pc_m, is_in_delayslot_m, alu_out_m,
               ri_m, break_m, syscall_m, overflow_m, adel_data_m, ades_data_m,
               pc_error_m, eret_m, cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
        input  cp0_rdata, flush_exception, pc_exception, exc_code,
               status_o, cause_o, epc_o, timer_int
    );

    modport slave (
        input  stall_m, valid_m, pc_m, is_in_delayslot_m, alu_out_m,
               ri_m, break_m, syscall_m, overflow_m, adel_data_m, ades_data_m,
               pc_error_m, eret_m, cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
        output cp0_rdata, flush_exception, pc_exception, exc_code,
               status_o, cause_o, epc_o, timer_int
    );

endinterface

// File: rtl/cp0_exception_unit_int_sync.sv
// Multi-flop synchroniser for the asynchronous external interrupt lines.
module cp0_exception_unit_int_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_stage[STAGES-1];

endmodule

// File: rtl/cp0_exception_unit.sv
// MEM-stage precise-exception unit: prioritises exceptions, redirects the PC and owns the CP0 state.
module cp0_exception_unit
    import cp0_exception_unit_pkg::*;
#(
    parameter int          N_HW_INT    = 6,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] EXC_VECTOR  = 32'hbfc0_0380
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_HW_INT-1:0] ext_int,
    cp0_exception_unit_if.slave bus
);

    logic [N_HW_INT-1:0] w_ext_sync;
    logic [31:0]         r_status;
    logic [31:0]         r_epc;
    logic [31:0]         r_badvaddr;
    logic [31:0]         r_count;
    logic [31:0]         r_compare;
    logic                r_presc;
    logic                r_bd;
    logic                r_ti;
    logic [1:0]          r_ip_sw;
    logic [4:0]          r_exccode;
    logic [5:0]          w_ip_hw;
    logic [31:0]         w_cause;
    logic                w_irq;
    logic                w_flush;
    exc_code_e           w_code;
    logic                w_commit;
    logic                w_mtc0;
    logic                w_count_wr;
    logic                w_compare_wr;
    logic [31:0]         w_count_inc;

    cp0_exception_unit_int_sync #(
        .WIDTH  (N_HW_INT),
        .STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (ext_int),
        .o_sync  (w_ext_sync)
    );

    // IP[7] shares the timer with the sixth hardware line when that line exists.
    always_comb begin
        w_ip_hw                 = '0;
        w_ip_hw[N_HW_INT-1:0]   = w_ext_sync;
        w_ip_hw[5]              = w_ip_hw[5] | r_ti;
    end

    always_comb begin
        w_cause                           = '0;
        w_cause[CAUSE_BD]                 = r_bd;
        w_cause[CAUSE_TI]                 = r_ti;
        w_cause[CAUSE_IP_LSB +: 8]        = {w_ip_hw, r_ip_sw};
        w_cause[CAUSE_EXC_LSB +: 5]       = r_exccode;
    end

    assign w_irq = r_status[STATUS_IE] & ~r_status[STATUS_EXL] & bus.valid_m &
                   (|(r_status[STATUS_IM_LSB +: 8] & w_cause[CAUSE_IP_LSB +: 8]));

    always_comb begin
        w_flush = 1'b1;
        w_code  = EXC_INT;
        if (w_irq) begin
            w_code = EXC_INT;
        end else if (bus.valid_m && (bus.adel_data_m || bus.pc_error_m)) begin
            w_code = EXC_ADEL;
        end else if (bus.valid_m && bus.ri_m) begin
            w_code = EXC_RI;
        end else if (bus.valid_m && bus.syscall_m) begin
            w_code = EXC_SYS;
        end else if (bus.valid_m && bus.break_m) begin
            w_code = EXC_BP;
        end else if (bus.valid_m && bus.ades_data_m) begin
            w_code = EXC_ADES;
        end else if (bus.valid_m && bus.overflow_m) begin
            w_code = EXC_OV;
        end else if (bus.valid_m && bus.eret_m) begin
            w_code = EXC_ERET;
        end else begin
            w_flush = 1'b0;
        end
    end

    assign bus.flush_exception = w_flush;
    assign bus.exc_code        = w_code;
    assign bus.pc_exception    = !w_flush            ? 32'd0 :
                                 (w_code == EXC_ERET) ? r_epc : EXC_VECTOR;

    // A committing exception swallows any MTC0 issued in the same cycle.
    assign w_commit     = w_flush & ~bus.stall_m;
    assign w_mtc0       = bus.cp0_we & ~bus.stall_m & ~w_commit;
    assign w_count_wr   = w_mtc0 && (bus.cp0_waddr == CP0_COUNT);
    assign w_compare_wr = w_mtc0 && (bus.cp0_waddr == CP0_COMPARE);
    assign w_count_inc  = r_count + 32'd1;

    // The timer keeps running through stalls so a Count/Compare match is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc   <= 1'b0;
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else begin
            r_presc <= ~r_presc;
            if (w_count_wr) begin
                r_count <= bus.cp0_wdata;
            end else if (r_presc) begin
                r_count <= w_count_inc;
            end
            if (w_compare_wr) begin
                r_compare <= bus.cp0_wdata;
                r_ti      <= 1'b0;
            end else if (r_presc && !w_count_wr && (w_count_inc == r_compare)) begin
                r_ti <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status   <= STATUS_RESET;
            r_epc      <= '0;
            r_badvaddr <= '0;
            r_bd       <= 1'b0;
            r_ip_sw    <= '0;
            r_exccode  <= '0;
        end else if (w_commit) begin
            if (w_code == EXC_ERET) begin
                r_status[STATUS_EXL] <= 1'b0;
            end else begin
                r_epc                <= bus.is_in_delayslot_m ? (bus.pc_m - 32'd4) : bus.pc_m;
                r_bd                 <= bus.is_in_delayslot_m;
                r_exccode            <= w_code;
                r_status[STATUS_EXL] <= 1'b1;
                if (w_code == EXC_ADEL || w_code == EXC_ADES) begin
                    r_badvaddr <= bus.pc_error_m ? bus.pc_m : bus.alu_out_m;
                end
            end
        end else if (w_mtc0) begin
            case (bus.cp0_waddr)
                CP0_STATUS: begin
                    r_status[STATUS_IM_LSB +: 8] <= bus.cp0_wdata[STATUS_IM_LSB +: 8];
                    r_status[STATUS_EXL]         <= bus.cp0_wdata[STATUS_EXL];
                    r_status[STATUS_IE]          <= bus.cp0_wdata[STATUS_IE];
                end
                CP0_CAUSE: r_ip_sw <= bus.cp0_wdata[CAUSE_IP_LSB +: 2];
                CP0_EPC:   r_epc   <= bus.cp0_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.cp0_rdata = '0;
        case (bus.cp0_raddr)
            CP0_BADVADDR: bus.cp0_rdata = r_badvaddr;
            CP0_COUNT:    bus.cp0_rdata = r_count;
            CP0_COMPARE:  bus.cp0_rdata = r_compare;
            CP0_STATUS:   bus.cp0_rdata = r_status;
            CP0_CAUSE:    bus.cp0_rdata = w_cause;
            CP0_EPC:      bus.cp0_rdata = r_epc;
            default:      bus.cp0_rdata = '0;
        endcase
    end

    assign bus.status_o  = r_status;
    assign bus.cause_o   = w_cause;
    assign bus.epc_o     = r_epc;
    assign bus.timer_int = r_ti;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed bench for cp0_exception_unit with a cycle-level reference model of the CP0 state.
module tb_cp0_exception_unit;

    localparam logic [31:0] EXC_VECTOR = 32'hbfc0_0380;
    localparam int          SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] ext_int = '0;
    int         total = 0;
    int         bad = 0;
    logic       auto_rd = 1'b1;
    int         rd_i = 0;
    logic [4:0] rtab [7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};

    cp0_exception_unit_if bus();

    cp0_exception_unit #(
        .N_HW_INT    (6),
        .SYNC_STAGES (SYNC_STAGES),
        .EXC_VECTOR  (EXC_VECTOR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ext_int (ext_int),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference state, kept as architectural fields rather than raw registers.
    logic        m_ie, m_exl, m_bd, m_ti;
    logic [7:0]  m_im;
    logic [1:0]  m_ipsw;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_badv, m_count, m_compare;
    int          m_edges;
    logic [5:0]  m_hist [$];

    logic [5:0]  ip_hw;
    logic [31:0] e_cause, e_status, e_pc, e_rdata, old_count, old_cmp;
    logic        e_flush, commit, mt, inc, cnt_wr, cmp_wr;
    logic [4:0]  e_code;
    logic        req [8];
    logic [4:0]  codes [8] = '{5'd0, 5'd4, 5'd10, 5'd8, 5'd9, 5'd5, 5'd12, 5'd31};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ie = 0; m_exl = 0; m_bd = 0; m_ti = 0; m_im = '0; m_ipsw = '0; m_exc = '0;
        m_epc = '0; m_badv = '0; m_count = '0; m_compare = '0; m_edges = 0;
        m_hist = {};
        for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(6'd0);
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            ip_hw    = m_hist[0];
            ip_hw[5] = ip_hw[5] | m_ti;
            e_cause  = {m_bd, m_ti, 14'd0, ip_hw, m_ipsw, 1'b0, m_exc, 2'b00};
            e_status = {9'd0, 1'b1, 6'd0, m_im, 6'd0, m_exl, m_ie};
            req[0] = m_ie & ~m_exl & (|(m_im & e_cause[15:8])) & bus.valid_m;
            req[1] = bus.valid_m & (bus.adel_data_m | bus.pc_error_m);
            req[2] = bus.valid_m & bus.ri_m;
            req[3] = bus.valid_m & bus.syscall_m;
            req[4] = bus.valid_m & bus.break_m;
            req[5] = bus.valid_m & bus.ades_data_m;
            req[6] = bus.valid_m & bus.overflow_m;
            req[7] = bus.valid_m & bus.eret_m;
            e_flush = 0; e_code = 0;
            for (int k = 0; k < 8; k++) begin
                if (!e_flush && req[k]) begin
                    e_flush = 1;
                    e_code  = codes[k];
                end
            end
            e_pc = !e_flush ? 32'd0 : (e_code == 5'd31) ? m_epc : EXC_VECTOR;
            case (bus.cp0_raddr)
                5'd8:    e_rdata = m_badv;
                5'd9:    e_rdata = m_count;
                5'd11:   e_rdata = m_compare;
                5'd12:   e_rdata = e_status;
                5'd13:   e_rdata = e_cause;
                5'd14:   e_rdata = m_epc;
                default: e_rdata = 32'd0;
            endcase
            check("cyc_flush",  32'(bus.flush_exception), 32'(e_flush));
            check("cyc_pcexc",  bus.pc_exception, e_pc);
            check("cyc_code",   32'(bus.exc_code), 32'(e_code));
            check("cyc_status", bus.status_o, e_status);
            check("cyc_cause",  bus.cause_o, e_cause);
            check("cyc_epc",    bus.epc_o, m_epc);
            check("cyc_ti",     32'(bus.timer_int), 32'(m_ti));
            check("cyc_rdata",  bus.cp0_rdata, e_rdata);
            if (!rst) begin
                commit    = e_flush & ~bus.stall_m;
                mt        = bus.cp0_we & ~bus.stall_m & ~commit;
                old_count = m_count;
                old_cmp   = m_compare;
                m_edges++;
                inc       = (m_edges % 2 == 0);
                if (commit) begin
                    if (e_code == 5'd31) begin
                        m_exl = 0;
                    end else begin
                        m_epc = bus.is_in_delayslot_m ? bus.pc_m - 32'd4 : bus.pc_m;
                        m_bd  = bus.is_in_delayslot_m;
                        m_exc = e_code;
                        m_exl = 1;
                        if (e_code == 5'd4 || e_code == 5'd5)
                            m_badv = bus.pc_error_m ? bus.pc_m : bus.alu_out_m;
                    end
                end else if (mt) begin
                    case (bus.cp0_waddr)
                        5'd12: begin
                            m_im  = bus.cp0_wdata[15:8];
                            m_exl = bus.cp0_wdata[1];
                            m_ie  = bus.cp0_wdata[0];
                        end
                        5'd13:   m_ipsw = bus.cp0_wdata[9:8];
                        5'd14:   m_epc  = bus.cp0_wdata;
                        default: ;
                    endcase
                end
                cnt_wr = mt && (bus.cp0_waddr == 5'd9);
                cmp_wr = mt && (bus.cp0_waddr == 5'd11);
                if (cnt_wr) m_count = bus.cp0_wdata;
                else if (inc) m_count = old_count + 32'd1;
                if (cmp_wr) begin
                    m_compare = bus.cp0_wdata;
                    m_ti      = 0;
                end else if (inc && !cnt_wr && (old_count + 32'd1 == old_cmp)) begin
                    m_ti = 1;
                end
                m_hist.push_back(ext_int);
                void'(m_hist.pop_front());
            end
        end
    end

    task automatic idle();
        bus.stall_m = 0; bus.valid_m = 0; bus.pc_m = '0; bus.is_in_delayslot_m = 0;
        bus.alu_out_m = '0; bus.ri_m = 0; bus.break_m = 0; bus.syscall_m = 0;
        bus.overflow_m = 0; bus.adel_data_m = 0; bus.ades_data_m = 0;
        bus.pc_error_m = 0; bus.eret_m = 0; bus.cp0_we = 0; bus.cp0_waddr = '0;
        bus.cp0_wdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (auto_rd) begin
            bus.cp0_raddr = rtab[rd_i];
            rd_i = (rd_i + 1) % 7;
        end
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        bus.cp0_we = 1; bus.cp0_waddr = a; bus.cp0_wdata = d;
        step();
        idle();
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        auto_rd = 0;
        bus.cp0_raddr = a;
        #1;
        check(name, bus.cp0_rdata, exp);
        auto_rd = 1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        idle();
        bus.cp0_raddr = '0;
        repeat (3) step();
        rst = 0;
        #1;
        check("rst_status", bus.status_o, 32'h0040_0000);
        check("rst_cause",  bus.cause_o, 32'h0);
        check("rst_epc",    bus.epc_o, 32'h0);
        check("rst_flush",  32'(bus.flush_exception), 32'h0);
        check("rst_ti",     32'(bus.timer_int), 32'h0);

        mtc0(5'd9, 32'h55);
        rd_chk("count_wr", 5'd9, 32'h55);
        rst = 1;
        #1;
        rd_chk("count_rst", 5'd9, 32'h0);
        check("midrst_status", bus.status_o, 32'h0040_0000);
        check("midrst_flush",  32'(bus.flush_exception), 32'h0);
        step();
        rst = 0;
        step();

        bus.valid_m = 1; bus.syscall_m = 1; bus.is_in_delayslot_m = 1; bus.pc_m = 32'hbfc0_1004;
        #1;
        check("sys_flush", 32'(bus.flush_exception), 32'h1);
        check("sys_pcexc", bus.pc_exception, 32'hbfc0_0380);
        check("sys_code",  32'(bus.exc_code), 32'd8);
        step(); idle(); #1;
        check("sys_epc",  bus.epc_o, 32'hbfc0_1000);
        check("sys_bd",   32'(bus.cause_o[31]), 32'h1);
        check("sys_exc",  32'(bus.cause_o[6:2]), 32'd8);
        check("sys_exl",  32'(bus.status_o[1]), 32'h1);

        bus.valid_m = 1; bus.pc_error_m = 1; bus.overflow_m = 1; bus.pc_m = 32'h8000_0002;
        #1;
        check("adel_code", 32'(bus.exc_code), 32'd4);
        step(); idle(); #1;
        check("adel_epc", bus.epc_o, 32'h8000_0002);
        check("adel_exc", 32'(bus.cause_o[6:2]), 32'd4);
        rd_chk("adel_badv", 5'd8, 32'h8000_0002);

        bus.valid_m = 1; bus.ri_m = 1; bus.break_m = 1; bus.syscall_m = 1; bus.pc_m = 32'h8000_0010;
        #1;
        check("ri_prio", 32'(bus.exc_code), 32'd10);
        step(); idle();

        bus.valid_m = 1; bus.ades_data_m = 1; bus.alu_out_m = 32'h0000_1235; bus.pc_m = 32'h8000_0020;
        #1;
        check("ades_code", 32'(bus.exc_code), 32'd5);
        step(); idle();
        rd_chk("ades_badv", 5'd8, 32'h0000_1235);

        bus.valid_m = 1; bus.eret_m = 1;
        #1;
        check("eret_pc",   bus.pc_exception, 32'h8000_0020);
        check("eret_code", 32'(bus.exc_code), 32'h1f);
        step(); idle(); #1;
        check("eret_exl", 32'(bus.status_o[1]), 32'h0);

        mtc0(5'd11, 32'd3);
        mtc0(5'd9, 32'd0);
        mtc0(5'd12, 32'h0000_8001);
        for (int i = 0; i < 20 && bus.timer_int !== 1'b1; i++) step();
        check("ti_rise", 32'(bus.timer_int), 32'h1);
        rd_chk("ti_count", 5'd9, 32'd3);
        bus.valid_m = 1; bus.pc_m = 32'h8000_1000;
        #1;
        check("tint_flush", 32'(bus.flush_exception), 32'h1);
        check("tint_code",  32'(bus.exc_code), 32'd0);
        step(); idle(); #1;
        check("tint_epc", bus.epc_o, 32'h8000_1000);
        check("tint_exl", 32'(bus.status_o[1]), 32'h1);
        mtc0(5'd11, 32'hffff_0000);
        #1;
        check("ti_clear", 32'(bus.timer_int), 32'h0);

        mtc0(5'd12, 32'h0000_1003);
        ext_int = 6'b000100;
        step(); #1;
        check("ip4_early", 32'(bus.cause_o[12]), 32'h0);
        step(); #1;
        check("ip4_sync", 32'(bus.cause_o[12]), 32'h1);
        bus.valid_m = 1; bus.pc_m = 32'h8000_2000;
        #1;
        check("exl_mask", 32'(bus.flush_exception), 32'h0);
        step();
        idle(); bus.valid_m = 1; bus.eret_m = 1;
        #1;
        check("eret2_pc",   bus.pc_exception, 32'h8000_1000);
        check("eret2_code", 32'(bus.exc_code), 32'h1f);
        step();
        idle(); bus.valid_m = 1; bus.pc_m = 32'h8000_3000;
        #1;
        check("hwint_exl",   32'(bus.status_o[1]), 32'h0);
        check("hwint_flush", 32'(bus.flush_exception), 32'h1);
        check("hwint_code",  32'(bus.exc_code), 32'd0);
        step(); idle(); #1;
        check("hwint_epc", bus.epc_o, 32'h8000_3000);

        ext_int = 6'b000000;
        bus.valid_m = 1; bus.eret_m = 1;
        step(); idle();
        repeat (3) step();

        bus.stall_m = 1; bus.valid_m = 1; bus.syscall_m = 1; bus.pc_m = 32'h8000_4000;
        bus.cp0_we = 1; bus.cp0_waddr = 5'd12; bus.cp0_wdata = 32'h0000_ff00;
        step(); #1;
        check("stall1_epc",    bus.epc_o, 32'h8000_3000);
        check("stall1_status", bus.status_o, 32'h0040_1001);
        check("stall1_flush",  32'(bus.flush_exception), 32'h1);
        step(); #1;
        check("stall2_epc",    bus.epc_o, 32'h8000_3000);
        check("stall2_status", bus.status_o, 32'h0040_1001);
        bus.stall_m = 0;
        step(); idle(); #1;
        check("rel_epc",    bus.epc_o, 32'h8000_4000);
        check("rel_status", bus.status_o, 32'h0040_1003);
        check("rel_exc",    32'(bus.cause_o[6:2]), 32'd8);

        mtc0(5'd13, 32'hffff_ffff);
        #1;
        check("cause_sw", bus.cause_o, 32'h0000_0320);
        repeat (8) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
